// File: rtl/inv_share_arbiter.sv
// Round-robin controller that time-shares one external inverter among NUM_REQ requesters,
// samples the inverter after a settle delay and flags any result that is not the inverse.
module inv_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SETTLE      = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] grant,
    output logic               inv_in,
    input  logic               inv_out,
    output logic               dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               fault,
    output logic [1:0]         state_o
);

    // Handshake: req[i] is a level request held until its grant ends; dropping it while
    // granted aborts the grant on the next edge. dout is meaningful only while dout_valid=1.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (SETTLE > HOLD_CYCLES) ? SETTLE : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_RESET   = PTR_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               inv_in_q, inv_in_d;
    logic               dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;

    logic               any_req;
    logic               found;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W:0]     probe;
    logic               req_sel;

    // Search upward from the slot after the last winner, wrapping at NUM_REQ.
    always_comb begin
        any_req = |req;
        found   = 1'b0;
        sel_idx = ptr_q;
        probe   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            probe = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (probe >= (PTR_W + 1)'(NUM_REQ)) begin
                probe = probe - (PTR_W + 1)'(NUM_REQ);
            end
            if (!found && req[probe[PTR_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = probe[PTR_W-1:0];
            end
        end
    end

    assign req_sel = req[ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= PTR_RESET;
            grant_q      <= '0;
            inv_in_q     <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            inv_in_q     <= inv_in_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    // Abort (requester dropped) takes priority over the timed transitions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!req_sel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!req_sel || (cnt_q == HOLD_LAST)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        inv_in_d     = inv_in_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        fault_d      = fault_q;
        busy_d       = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d  = NUM_REQ'(1) << sel_idx;
                    inv_in_d = din[sel_idx];
                    ptr_d    = sel_idx;
                end
            end
            ST_SETTLE: begin
                if (!req_sel) begin
                    grant_d      = '0;
                    dout_valid_d = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    dout_d       = inv_out;
                    dout_valid_d = 1'b1;
                    if (inv_out != ~inv_in_q) begin
                        fault_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!req_sel || (cnt_q == HOLD_LAST)) begin
                    grant_d      = '0;
                    dout_valid_d = 1'b0;
                end
            end
            default: begin
                grant_d      = '0;
                dout_valid_d = 1'b0;
            end
        endcase
    end

    assign grant      = grant_q;
    assign inv_in     = inv_in_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_inv_share_arbiter.sv
// Directed bench for inv_share_arbiter: stimulus pushes expected grants, samples and
// durations; a negedge monitor pops and compares them as the DUT produces them.
module tb_inv_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] grant;
    logic       inv_in;
    logic       inv_out;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       fault;
    logic [1:0] state_o;

    logic tie_en;
    logic tie_val;
    logic gap_check;

    int n_checks;
    int n_fail;

    logic [3:0] exp_grant_q[$];
    logic [1:0] exp_dv_q[$];
    logic [3:0] exp_glen_q[$];
    logic [3:0] exp_dvlen_q[$];

    // External inverter: ideal unless the bench ties its output.
    assign inv_out = tie_en ? tie_val : ~inv_in;

    inv_share_arbiter #(.NUM_REQ(4), .SETTLE(2), .HOLD_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .grant      (grant),
        .inv_in     (inv_in),
        .inv_out    (inv_out),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .fault      (fault),
        .state_o    (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event with empty expectation queue at %0t", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input logic [3:0] g, input logic d, input logic f,
                              input logic [3:0] glen, input logic [3:0] dvlen);
        exp_grant_q.push_back(g);
        exp_dv_q.push_back({d, f});
        exp_glen_q.push_back(glen);
        exp_dvlen_q.push_back(dvlen);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_inv_in"}, 32'(inv_in), 32'h0);
        check({tag, "_dout"}, 32'(dout), 32'h0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_fault"}, 32'(fault), 32'h0);
        check({tag, "_state"}, 32'(state_o), 32'h0);
    endtask

    // Monitor: compares grant value, grant length, sampled result and valid length.
    initial begin
        logic [3:0] prev_grant;
        logic       prev_dv;
        int         g_len;
        int         dv_len;
        int         idle_len;
        prev_grant = '0;
        prev_dv    = 1'b0;
        g_len      = 0;
        dv_len     = 0;
        idle_len   = 0;
        forever begin
            @(negedge clk);
            if (grant != 4'b0 && prev_grant == 4'b0) begin
                if (gap_check) check("rr_gap", 32'(idle_len), 32'd1);
                if (exp_grant_q.size() == 0) fail_now("grant_value");
                else check("grant_value", 32'(grant), 32'(exp_grant_q.pop_front()));
                g_len = 1;
            end else if (grant != 4'b0) begin
                check("grant_stable", 32'(grant), 32'(prev_grant));
                g_len++;
            end else if (prev_grant != 4'b0) begin
                if (exp_glen_q.size() == 0) fail_now("grant_len");
                else check("grant_len", 32'(g_len), 32'(exp_glen_q.pop_front()));
                idle_len = 1;
            end else begin
                idle_len++;
            end

            if (dout_valid && !prev_dv) begin
                if (exp_dv_q.size() == 0) fail_now("sample_dout_fault");
                else check("sample_dout_fault", 32'({dout, fault}), 32'(exp_dv_q.pop_front()));
                dv_len = 1;
            end else if (dout_valid) begin
                dv_len++;
            end else if (prev_dv) begin
                if (exp_dvlen_q.size() == 0) fail_now("valid_len");
                else check("valid_len", 32'(dv_len), 32'(exp_dvlen_q.pop_front()));
            end
            prev_grant = grant;
            prev_dv    = dout_valid;
        end
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        req       = '0;
        din       = '0;
        rst_n     = 1'b0;
        tie_en    = 1'b0;
        tie_val   = 1'b0;
        gap_check = 1'b0;

        tick(2);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Single request, ideal inverter.
        expect_txn(4'b0001, 1'b0, 1'b0, 4'd6, 4'd4);
        req = 4'b0001;
        din = 4'b0001;
        tick(1);
        check("t1_inv_in", 32'(inv_in), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        tick(6);
        req = '0;
        tick(2);

        // Round-robin from a fresh pointer with continuous requests.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        din = 4'b1010;
        expect_txn(4'b0001, 1'b1, 1'b0, 4'd6, 4'd4);
        expect_txn(4'b0010, 1'b0, 1'b0, 4'd6, 4'd4);
        expect_txn(4'b0100, 1'b1, 1'b0, 4'd6, 4'd4);
        expect_txn(4'b1000, 1'b0, 1'b0, 4'd6, 4'd4);
        expect_txn(4'b0001, 1'b1, 1'b0, 4'd6, 4'd4);
        req = 4'b1111;
        tick(2);
        gap_check = 1'b1;
        tick(28);
        gap_check = 1'b0;
        tick(5);
        req = '0;
        tick(2);

        // Abort on the second HOLD cycle, then 0 wins over 1 after pointer=2.
        din = 4'b0100;
        expect_txn(4'b0100, 1'b0, 1'b0, 4'd4, 4'd2);
        req = 4'b0100;
        tick(4);
        req = '0;
        tick(1);
        check("t3_abort_grant", 32'(grant), 32'h0);
        check("t3_abort_valid", 32'(dout_valid), 32'h0);
        check("t3_abort_busy", 32'(busy), 32'h0);
        check("t3_abort_dout", 32'(dout), 32'h0);
        expect_txn(4'b0001, 1'b1, 1'b0, 4'd6, 4'd4);
        req = 4'b0011;
        tick(7);
        req = '0;
        tick(2);

        // Faulty inverter output, then fault must stick through a correct transaction.
        tie_en  = 1'b1;
        tie_val = 1'b1;
        din = 4'b0010;
        expect_txn(4'b0010, 1'b1, 1'b1, 4'd6, 4'd4);
        req = 4'b0010;
        tick(7);
        req = '0;
        tie_en = 1'b0;
        tick(2);
        check("t4_fault_sticky", 32'(fault), 32'h1);
        din = 4'b0001;
        expect_txn(4'b0001, 1'b0, 1'b1, 4'd6, 4'd4);
        req = 4'b0001;
        tick(7);
        req = '0;
        tick(2);

        // Reset in the middle of HOLD; afterwards requester 0 beats 3.
        din = 4'b0100;
        expect_txn(4'b0100, 1'b0, 1'b1, 4'd4, 4'd2);
        req = 4'b0100;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check_idle_outputs("t5_reset");
        rst_n = 1'b1;
        req = 4'b1001;
        din = 4'b1000;
        expect_txn(4'b0001, 1'b1, 1'b0, 4'd6, 4'd4);
        expect_txn(4'b1000, 1'b0, 1'b0, 4'd6, 4'd4);
        tick(14);
        req = '0;
        tick(2);

        // din changes after the grant must not reach inv_in or dout.
        din = 4'b0001;
        expect_txn(4'b0001, 1'b0, 1'b0, 4'd6, 4'd4);
        req = 4'b0001;
        tick(1);
        din = 4'b0000;
        tick(1);
        check("t6_inv_in_latched", 32'(inv_in), 32'h1);
        tick(5);
        req = '0;
        tick(3);

        check("leftover_grant", 32'(exp_grant_q.size()), 32'd0);
        check("leftover_sample", 32'(exp_dv_q.size()), 32'd0);
        check("leftover_grant_len", 32'(exp_glen_q.size()), 32'd0);
        check("leftover_valid_len", 32'(exp_dvlen_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_share_arbiter.md
Name: inv_share_arbiter

Overview:
- Shares one external inverter stage among NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's data bit into the inverter input.
- Waits a fixed settle time for the inverter's propagation delay, then presents the sampled result for a fixed hold window.
- Flags any sample that is not the logical inverse of the latched input; this is the board-level controller placed in front of the inverter cell.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SETTLE, 2, cycles from driving inv_in to sampling inv_out (>=1)
HOLD_CYCLES, 4, cycles dout_valid stays high per grant (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  NUM_REQ  per-requester request, level, held until grant ends
din  input  NUM_REQ  per-requester data bit to be inverted
grant  output  NUM_REQ  one-hot grant, registered
inv_in  output  1  drive to shared inverter input, registered
inv_out  input  1  shared inverter output
dout  output  1  sampled inverter result, registered
dout_valid  output  1  dout valid for granted requester
busy  output  1  high in any state other than IDLE
fault  output  1  sticky: sampled inv_out != ~latched din

Behaviour:
- Reset (rst_n low at a clock edge), all registered:
  - grant=0, inv_in=0, dout=0, dout_valid=0, busy=0, fault=0, state=IDLE, counter=0.
  - Priority pointer = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-operation aborts the current grant immediately.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - If any req bit is set, select the first set bit searching upward (with wrap) from pointer+1.
  - Next edge: grant[sel]=1, inv_in=din[sel] (latched, later din changes ignored), pointer=sel, counter=0, busy=1, state=SETTLE.
  - With no req bits set, stay in IDLE.
- SETTLE:
  - counter increments each cycle.
  - On the edge where counter==SETTLE-1: dout=inv_out, dout_valid=1, counter=0, state=HOLD.
  - At the same edge, if inv_out != ~inv_in, set fault; it stays set until reset.
- HOLD:
  - dout is held constant and dout_valid=1.
  - On the edge where counter==HOLD_CYCLES-1: grant=0, dout_valid=0, busy=0, state=IDLE. dout keeps its last value.
- Grant duration: grant stays high for exactly SETTLE+HOLD_CYCLES cycles. The first grant is registered one cycle after req is sampled.
- Minimum gap: at least one IDLE cycle (grant=0) separates consecutive grants, even when requests are continuous.
- Abort: if req[sel] drops while in SETTLE or HOLD, the next edge sets grant=0, dout_valid=0, busy=0, state=IDLE. dout is not updated, fault is not evaluated, and the pointer keeps sel.
- Simultaneous events:
  - The abort check has priority over the SETTLE->HOLD and HOLD->IDLE transitions.
  - Requests from other requesters are ignored until IDLE.
- inv_in holds its last value when idle. It is changed only at a new grant.
- Fairness: with all requesters asserting continuously, grants cycle 0,1,2,...,NUM_REQ-1,0 with no starvation.

Test Plan:
1. Reset, then single request: req=0001, din[0]=1, ideal inverter (inv_out=~inv_in); defaults.
   - grant=0001 one cycle after req; inv_in=1.
   - dout_valid rises 2 cycles later with dout=0 and stays high 4 cycles.
   - grant lasts 6 cycles; fault=0.
2. Round-robin: req=1111 held continuously.
   - Grant order is 0001, 0010, 0100, 1000, 0001.
   - Each grant lasts 6 cycles, with a 1-cycle grant=0 gap between grants.
3. Abort: req=0100; drop req[2] on the 2nd HOLD cycle.
   - Next edge: grant=0, dout_valid=0, busy=0.
   - dout keeps the sampled value; the next request from 0 wins if req=0011.
4. Fault: tie inv_out=1 while din[1]=1 (inv_in=1).
   - At the sample edge fault=1 and dout=1.
   - fault stays 1 through later correct transactions until rst_n=0.
5. Reset mid-HOLD: assert rst_n=0 for one edge.
   - All outputs return to 0 and state is IDLE.
   - With req=1000 and req=0001 both present afterwards, requester 0 is granted first.
6. Latched data: change din[0] during SETTLE.
   - inv_in is unchanged and dout reflects the value latched at grant.
